miner_host_ctrl: RTL and testbench

MINER_HOST_CTRL -- requirements
Module: miner_host_ctrl

---
 rtl/miner_host_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_miner_host_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_host_ctrl.sv
// Host-side job controller for a mining core: streams the header, then runs
// nonces one at a time over the core network, tracking barriers and a watchdog.
module miner_host_ctrl #(
    parameter logic [9:0]  ID_P      = 10'd1,
    parameter logic [2:0]  OP_NULL_P = 3'd0,
    parameter logic [2:0]  OP_REG_P  = 3'd1,
    parameter logic [2:0]  OP_PC_P   = 3'd2,
    parameter logic [2:0]  OP_BAR_P  = 3'd3,
    parameter logic [31:0] TIMEOUT_P = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        work_we_i,
    input  logic [3:0]  work_addr_i,
    input  logic [31:0] work_data_i,
    input  logic        start_i,
    input  logic [31:0] nonce_start_i,
    input  logic [31:0] nonce_limit_i,
    input  logic [2:0]  barrier_i,
    output logic [9:0]  pkt_id_o,
    output logic [2:0]  pkt_op_o,
    output logic [4:0]  pkt_reserved_o,
    output logic [31:0] pkt_data_o,
    output logic [9:0]  pkt_addr_o,
    output logic        busy_o,
    output logic        found_o,
    output logic        exhausted_o,
    output logic        timeout_o,
    output logic [31:0] found_nonce_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_BAR, S_HDR, S_CMD, S_PC, S_REL, S_WAIT, S_SETTLE,
        S_NONCE, S_NCMD, S_FCMD, S_DONE, S_ERR
    } state_t;

    state_t      state, next;
    logic [31:0] header [0:10];
    logic [3:0]  word;
    logic [31:0] cnt;
    logic [31:0] nonce_r, limit_r;
    logic        found_flag;
    logic        nonce_run;
    logic        fin;

    logic        load_job, set_exh, set_to, inc_nonce, wait_exit, wait_found;
    logic        to_hit;

    assign to_hit = ({1'b0, cnt} + 33'd1) >= {1'b0, TIMEOUT_P};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 11; i++) header[i] <= '0;
        end else if (work_we_i && work_addr_i <= 4'd10) begin
            header[work_addr_i] <= work_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next       = state;
        load_job   = 1'b0;
        set_exh    = 1'b0;
        set_to     = 1'b0;
        inc_nonce  = 1'b0;
        wait_exit  = 1'b0;
        wait_found = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    next     = S_BAR;
                    load_job = 1'b1;
                end
            end
            S_BAR:   next = S_HDR;
            S_HDR:   if (word == 4'd10) next = S_CMD;
            S_CMD:   next = S_PC;
            S_PC:    next = S_REL;
            S_REL:   next = fin ? S_DONE : S_WAIT;
            S_WAIT: begin
                // The core's barrier input is registered; the first two readings are stale.
                if (cnt >= 32'd2 && (barrier_i == 3'b000 || barrier_i == 3'b001)) begin
                    next       = S_SETTLE;
                    wait_exit  = 1'b1;
                    wait_found = (barrier_i == 3'b001);
                end else if (to_hit) begin
                    next   = S_ERR;
                    set_to = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == 32'd1) begin
                    if (found_flag) begin
                        next = S_FCMD;
                    end else if (!nonce_run) begin
                        next = S_NONCE;
                    end else if (nonce_r == limit_r) begin
                        next    = S_DONE;
                        set_exh = 1'b1;
                    end else begin
                        next      = S_NONCE;
                        inc_nonce = 1'b1;
                    end
                end
            end
            S_NONCE: next = S_NCMD;
            S_NCMD:  next = S_PC;
            S_FCMD:  next = S_PC;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word          <= '0;
            cnt           <= '0;
            nonce_r       <= '0;
            limit_r       <= '0;
            found_flag    <= 1'b0;
            nonce_run     <= 1'b0;
            fin           <= 1'b0;
            found_o       <= 1'b0;
            exhausted_o   <= 1'b0;
            timeout_o     <= 1'b0;
            found_nonce_o <= '0;
        end else begin
            if (load_job) begin
                nonce_r     <= nonce_start_i;
                limit_r     <= nonce_limit_i;
                found_flag  <= 1'b0;
                fin         <= 1'b0;
                found_o     <= 1'b0;
                exhausted_o <= 1'b0;
                timeout_o   <= 1'b0;
            end
            if (state == S_BAR) word <= '0;
            else if (state == S_HDR) word <= word + 4'd1;

            if (state == S_REL || wait_exit) cnt <= '0;
            else if (state == S_WAIT || state == S_SETTLE) cnt <= cnt + 32'd1;

            if (wait_exit) found_flag <= wait_found;
            if (state == S_CMD)  nonce_run <= 1'b0;
            if (state == S_NCMD) nonce_run <= 1'b1;
            if (inc_nonce) nonce_r <= nonce_r + 32'd1;
            if (state == S_FCMD) begin
                fin           <= 1'b1;
                found_o       <= 1'b1;
                found_nonce_o <= nonce_r;
            end
            if (set_exh) exhausted_o <= 1'b1;
            if (set_to)  timeout_o   <= 1'b1;
        end
    end

    always_comb begin
        pkt_id_o       = ID_P;
        pkt_reserved_o = '0;
        pkt_op_o       = OP_NULL_P;
        pkt_data_o     = 32'hFFFF_FFFE;
        pkt_addr_o     = 10'd24;
        case (state)
            S_BAR: begin
                pkt_op_o   = OP_BAR_P;
                pkt_data_o = 32'd7;
                pkt_addr_o = 10'd24;
            end
            S_HDR: begin
                pkt_op_o   = OP_REG_P;
                pkt_data_o = header[word];
                pkt_addr_o = {6'd0, word} + 10'd1;
            end
            S_CMD: begin
                pkt_op_o   = OP_REG_P;
                pkt_data_o = 32'd1;
                pkt_addr_o = 10'd20;
            end
            S_PC: begin
                pkt_op_o   = OP_PC_P;
                pkt_data_o = 32'd2;
                pkt_addr_o = 10'd0;
            end
            S_NONCE: begin
                pkt_op_o   = OP_REG_P;
                pkt_data_o = nonce_r;
                pkt_addr_o = 10'd1;
            end
            S_NCMD: begin
                pkt_op_o   = OP_REG_P;
                pkt_data_o = 32'd2;
                pkt_addr_o = 10'd20;
            end
            S_FCMD: begin
                pkt_op_o   = OP_REG_P;
                pkt_data_o = 32'd3;
                pkt_addr_o = 10'd20;
            end
            default: ;
        endcase
    end

    assign busy_o = !(state == S_IDLE || state == S_DONE || state == S_ERR);

endmodule

// File: tb/tb_miner_host_ctrl.sv
// Bench for miner_host_ctrl: a job-level model expands each job into the
// expected per-cycle packet/status trace, which is compared every cycle.
module tb_miner_host_ctrl;

    localparam logic [9:0]  ID    = 10'd37;
    localparam int unsigned TMO   = 50;
    localparam logic [2:0]  NUL   = 3'd0;
    localparam logic [2:0]  REG   = 3'd1;
    localparam logic [2:0]  PCO   = 3'd2;
    localparam logic [2:0]  BARO  = 3'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        work_we_i = 1'b0;
    logic [3:0]  work_addr_i = '0;
    logic [31:0] work_data_i = '0;
    logic        start_i = 1'b0;
    logic [31:0] nonce_start_i = '0;
    logic [31:0] nonce_limit_i = '0;
    logic [2:0]  barrier_i = '0;
    logic [9:0]  pkt_id_o;
    logic [2:0]  pkt_op_o;
    logic [4:0]  pkt_reserved_o;
    logic [31:0] pkt_data_o;
    logic [9:0]  pkt_addr_o;
    logic        busy_o, found_o, exhausted_o, timeout_o;
    logic [31:0] found_nonce_o;

    miner_host_ctrl #(.ID_P(ID), .TIMEOUT_P(32'd50)) dut (
        .clk(clk), .reset(reset),
        .work_we_i(work_we_i), .work_addr_i(work_addr_i), .work_data_i(work_data_i),
        .start_i(start_i), .nonce_start_i(nonce_start_i), .nonce_limit_i(nonce_limit_i),
        .barrier_i(barrier_i),
        .pkt_id_o(pkt_id_o), .pkt_op_o(pkt_op_o), .pkt_reserved_o(pkt_reserved_o),
        .pkt_data_o(pkt_data_o), .pkt_addr_o(pkt_addr_o),
        .busy_o(busy_o), .found_o(found_o), .exhausted_o(exhausted_o),
        .timeout_o(timeout_o), .found_nonce_o(found_nonce_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic [2:0]  bar;
        logic        found, exh, to;
        logic [31:0] fn;
    } ent_t;

    ent_t        tr[$];
    logic [31:0] hdr [0:10];
    int unsigned run_w [0:7];
    logic [2:0]  run_v [0:7];
    logic        m_found, m_exh, m_to;
    logic [31:0] m_fn;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [2:0] op, input logic [9:0] addr,
                                 input logic [31:0] data, input logic busy, input logic [2:0] bar);
        ent_t e;
        e.op = op; e.addr = addr; e.data = data; e.busy = busy; e.bar = bar;
        e.found = m_found; e.exh = m_exh; e.to = m_to; e.fn = m_fn;
        tr.push_back(e);
    endfunction

    function automatic void push_null(input logic busy, input logic [2:0] bar);
        push(NUL, 10'd24, 32'hFFFF_FFFE, busy, bar);
    endfunction

    function automatic void clear_runs();
        for (int i = 0; i < 8; i++) begin
            run_w[i] = 0;
            run_v[i] = 3'b000;
        end
    endfunction

    // Expand one job into its cycle trace from the protocol rules.
    function automatic void build_job(input logic [31:0] ns, input logic [31:0] nl);
        logic [31:0] nonce;
        logic [2:0]  b;
        int unsigned w;
        logic [2:0]  v;
        tr.delete();
        m_found = 1'b0; m_exh = 1'b0; m_to = 1'b0;
        nonce = ns;
        push(BARO, 10'd24, 32'd7, 1'b1, 3'b000);
        for (int k = 0; k < 11; k++) push(REG, 10'(k + 1), hdr[k], 1'b1, 3'b000);
        push(REG, 10'd20, 32'd1, 1'b1, 3'b000);
        push(PCO, 10'd0, 32'd2, 1'b1, 3'b000);
        push_null(1'b1, 3'b000);
        for (int r = 0; r < 64; r++) begin
            w = (r < 8) ? run_w[r] : 0;
            v = (r < 8) ? run_v[r] : 3'b000;
            b = 3'b000;
            for (int unsigned c = 0; c < TMO; c++) begin
                b = (c < w) ? 3'b010 : v;
                push_null(1'b1, b);
                if (c >= 2 && (b == 3'b000 || b == 3'b001)) break;
                if (c == TMO - 1) m_to = 1'b1;
            end
            if (m_to) break;
            push_null(1'b1, v);
            push_null(1'b1, v);
            if (b == 3'b001) begin
                push(REG, 10'd20, 32'd3, 1'b1, 3'b000);
                m_found = 1'b1; m_fn = nonce;
                push(PCO, 10'd0, 32'd2, 1'b1, 3'b000);
                push_null(1'b1, 3'b000);
                break;
            end
            if (r != 0) begin
                if (nonce == nl) begin
                    m_exh = 1'b1;
                    break;
                end
                nonce = nonce + 32'd1;
            end
            push(REG, 10'd1, nonce, 1'b1, 3'b000);
            push(REG, 10'd20, 32'd2, 1'b1, 3'b000);
            push(PCO, 10'd0, 32'd2, 1'b1, 3'b000);
            push_null(1'b1, 3'b000);
        end
        for (int d = 0; d < 3; d++) push_null(1'b0, 3'b000);
    endfunction

    task automatic check_idle_null(input string tag);
        chk({tag, "_pkt"}, {pkt_id_o, pkt_op_o, pkt_reserved_o, pkt_addr_o, pkt_data_o},
            {ID, NUL, 5'd0, 10'd24, 32'hFFFF_FFFE});
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    endtask

    // Drive the job and compare the DUT against the trace every cycle.
    task automatic run_job(input logic [31:0] ns, input logic [31:0] nl, input int abort_at);
        @(posedge clk); #1;
        start_i = 1'b1; nonce_start_i = ns; nonce_limit_i = nl; barrier_i = 3'b000;
        for (int i = 0; i < tr.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) start_i = 1'b0;
            if (i == 3) begin start_i = 1'b1; nonce_start_i = 32'hDEAD_0000; end
            if (i == 4) start_i = 1'b0;
            chk($sformatf("pkt[%0d]", i),
                {pkt_id_o, pkt_op_o, pkt_reserved_o, pkt_addr_o, pkt_data_o},
                {ID, tr[i].op, 5'd0, tr[i].addr, tr[i].data});
            chk($sformatf("busy[%0d]", i), {63'd0, busy_o}, {63'd0, tr[i].busy});
            chk($sformatf("status[%0d]", i), {61'd0, found_o, exhausted_o, timeout_o},
                {61'd0, tr[i].found, tr[i].exh, tr[i].to});
            if (tr[i].found)
                chk($sformatf("found_nonce[%0d]", i), {32'd0, found_nonce_o}, {32'd0, tr[i].fn});
            barrier_i = tr[i].bar;
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check_idle_null("abort");
                break;
            end
        end
        barrier_i = 3'b000;
    endtask

    task automatic write_hdr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        work_we_i = 1'b1; work_addr_i = a; work_data_i = d;
        if (a <= 4'd10) hdr[a] = d;
        @(posedge clk); #1;
        work_we_i = 1'b0;
    endtask

    function automatic int busy_count();
        int n = 0;
        foreach (tr[i]) if (tr[i].busy) n++;
        return n;
    endfunction

    function automatic int first_timeout();
        foreach (tr[i]) if (tr[i].to) return i;
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 11; k++) hdr[k] = '0;
        m_fn = '0;
        #7;
        chk("rst_pkt", {pkt_id_o, pkt_op_o, pkt_reserved_o, pkt_addr_o, pkt_data_o},
            {ID, NUL, 5'd0, 10'd24, 32'hFFFF_FFFE});
        chk("rst_status", {59'd0, busy_o, found_o, exhausted_o, timeout_o, 1'b0}, 64'd0);
        chk("rst_found_nonce", {32'd0, found_nonce_o}, 64'd0);
        @(negedge clk); reset = 1'b1;

        for (int k = 0; k < 11; k++) write_hdr(4'(k), 32'hA5A5_0000 + 32'(k) * 32'h0101);
        write_hdr(4'd12, 32'h1234_5678);

        // nonce 0..0, barrier idle at 000
        clear_runs();
        build_job(32'd0, 32'd0);
        chk("model_jobA_busy_cycles", 64'(busy_count()), 64'd29);
        run_job(32'd0, 32'd0, -1);
        chk("jobA_exhausted", {63'd0, exhausted_o}, 64'd1);

        // nonce 5..7 with barrier busy for 4 cycles every run
        clear_runs();
        for (int i = 0; i < 8; i++) run_w[i] = 4;
        build_job(32'd5, 32'd7);
        run_job(32'd5, 32'd7, -1);
        chk("jobB_status", {62'd0, found_o, exhausted_o}, 64'd1);

        // nonce 0..100, found during nonce 3
        clear_runs();
        run_w[4] = 5; run_v[4] = 3'b001;
        build_job(32'd0, 32'd100);
        chk("model_jobC_fn", {32'd0, m_fn}, 64'd3);
        run_job(32'd0, 32'd100, -1);
        chk("jobC_found_nonce", {32'd0, found_nonce_o}, 64'd3);
        chk("jobC_found", {63'd0, found_o}, 64'd1);

        // single nonce at the top of the range
        clear_runs();
        build_job(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("model_jobD_busy_cycles", 64'(busy_count()), 64'd29);
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("jobD_exhausted", {63'd0, exhausted_o}, 64'd1);

        // barrier stuck at 010 -> watchdog
        clear_runs();
        run_v[0] = 3'b010;
        build_job(32'd9, 32'd9);
        chk("model_jobE_timeout_idx", 64'(first_timeout()), 64'd65);
        run_job(32'd9, 32'd9, -1);
        chk("jobE_timeout_idle", {62'd0, timeout_o, busy_o}, 64'd2);

        // reset during header word 4, then replay with the cleared store
        clear_runs();
        build_job(32'd0, 32'd0);
        run_job(32'd0, 32'd0, 5);
        @(posedge clk); #1;
        check_idle_null("in_reset");
        reset = 1'b1;
        for (int k = 0; k < 11; k++) hdr[k] = '0;
        m_fn = '0;
        @(posedge clk); #1;
        check_idle_null("after_reset");
        chk("after_reset_status", {61'd0, found_o, exhausted_o, timeout_o}, 64'd0);
        build_job(32'd0, 32'd0);
        run_job(32'd0, 32'd0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
